// File: rtl/icache_mem_nway_pkg.sv
// -----------------------------------------------------------------------------
// icache_mem_nway_pkg
// Shared types and default geometry for the N-way icache storage block.
//   ICACHE_*            : default geometry used by the top-level parameters
//   icache_tag_entry_t  : stored tag entry, {valid, tag}
//   icache_mem_state_e  : storage FSM states (IDLE = serving, INIT = tag sweep)
// -----------------------------------------------------------------------------
package icache_mem_nway_pkg;

  localparam int ICACHE_WAYS    = 4;
  localparam int ICACHE_INDEX_W = 6;
  localparam int ICACHE_TAG_W   = 20;
  localparam int ICACHE_LINE_W  = 512;
  localparam int ICACHE_BANKS   = 2;

  // Stored tag entry at the default geometry; the top re-declares the same
  // layout against its own TAG_W parameter.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
  } icache_tag_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } icache_mem_state_e;

  // Width of a single data bank for a given line width and bank count.
  function automatic int icache_bank_w(input int line_w, input int banks);
    return line_w / banks;
  endfunction

endpackage : icache_mem_nway_pkg

// File: rtl/icache_way_mem.sv
// -----------------------------------------------------------------------------
// icache_way_mem
// Storage for one way of the icache: one tag array plus BANKS data banks.
// All arrays share one address. Each array is a single-port synchronous SRAM:
// when enabled it either writes (we=1) or reads (we=0). The read data register
// is only updated by reads, so a write never disturbs a lookup result that is
// still being consumed downstream.
//
// Ports:
//   clk                 clock
//   addr                set index shared by tag array and data banks
//   tag_en / tag_we     tag array enable / write enable
//   tag_din / tag_dout  tag entry in / registered tag entry out ({valid, tag})
//   data_en / data_we   enable / write enable for all data banks of this way
//   data_din/data_dout  full cacheline in / registered cacheline out
// -----------------------------------------------------------------------------
module icache_way_mem
  import icache_mem_nway_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = ICACHE_TAG_W,
  parameter int LINE_W  = ICACHE_LINE_W,
  parameter int BANKS   = ICACHE_BANKS
) (
  input  logic              clk,
  input  logic [INDEX_W-1:0] addr,
  input  logic              tag_en,
  input  logic              tag_we,
  input  logic [TAG_W:0]    tag_din,
  output logic [TAG_W:0]    tag_dout,
  input  logic              data_en,
  input  logic              data_we,
  input  logic [LINE_W-1:0] data_din,
  output logic [LINE_W-1:0] data_dout
);

  localparam int DEPTH  = 2 ** INDEX_W;
  localparam int BANK_W = icache_bank_w(LINE_W, BANKS);

  // Tag array
  logic [TAG_W:0] tag_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (tag_en) begin
      if (tag_we) begin
        tag_mem[addr] <= tag_din;
      end else begin
        tag_dout <= tag_mem[addr];
      end
    end
  end

  // Data banks: bank b holds line bits [(b+1)*BANK_W-1 : b*BANK_W]. The
  // banks are never cleared; validity lives only in the tag array.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [BANK_W-1:0] bank_mem [DEPTH];
    logic [BANK_W-1:0] bank_dout;

    always_ff @(posedge clk) begin
      if (data_en) begin
        if (data_we) begin
          bank_mem[addr] <= data_din[b*BANK_W +: BANK_W];
        end else begin
          bank_dout <= bank_mem[addr];
        end
      end
    end

    assign data_dout[b*BANK_W +: BANK_W] = bank_dout;
  end

endmodule : icache_way_mem

// File: rtl/icache_mem_nway.sv
// -----------------------------------------------------------------------------
// icache_mem_nway
// N-way set-associative icache storage: per-way tag arrays and banked data
// arrays, a two-stage lookup pipeline with tag compare, a refill/invalidate
// write port, and a tag-clear sweep after reset and on flush.
//
// Handshake: a lookup is transferred in a cycle where rd_vld & rd_rdy; rd_rdy
// is low while the tag sweep runs or a write is presented (sweep > write >
// lookup). Writes have no ready: they are taken whenever init_busy is low and
// silently dropped otherwise. Responses (rsp_*) have no backpressure: rsp_vld
// is high for exactly one cycle, two cycles after the lookup was accepted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_req           pulse: invalidate all sets (ignored during sweep)
//   init_busy           tag sweep in progress
//   rd_vld/rd_rdy       lookup request handshake
//   rd_index/rd_tag     lookup set and tag
//   rsp_vld             lookup response valid
//   rsp_hit             any way hit
//   rsp_hit_way         one-hot hit vector
//   rsp_multi_hit       more than one way hit
//   rsp_line            OR of hitting lines, zero on miss
//   wr_vld              refill/invalidate write
//   wr_index/wr_way     write set and way (binary)
//   wr_valid/wr_tag     tag entry written
//   wr_data_en/wr_line  also write the cacheline (refill)
//   state_dbg           current storage FSM state
// -----------------------------------------------------------------------------
module icache_mem_nway
  import icache_mem_nway_pkg::*;
#(
  parameter int WAYS    = ICACHE_WAYS,
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = ICACHE_TAG_W,
  parameter int LINE_W  = ICACHE_LINE_W,
  parameter int BANKS   = ICACHE_BANKS,
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  output logic               init_busy,
  input  logic               rd_vld,
  output logic               rd_rdy,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rsp_vld,
  output logic               rsp_hit,
  output logic [WAYS-1:0]    rsp_hit_way,
  output logic               rsp_multi_hit,
  output logic [LINE_W-1:0]  rsp_line,
  input  logic               wr_vld,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WAY_W-1:0]   wr_way,
  input  logic               wr_valid,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_data_en,
  input  logic [LINE_W-1:0]  wr_line,
  output icache_mem_state_e  state_dbg
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  icache_mem_state_e  state, state_nxt;
  logic [INDEX_W-1:0] sweep_cnt, sweep_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  // INIT clears one set per cycle in every way and leaves after the last set,
  // so the machine sits in INIT for exactly DEPTH cycles. flush_req is only
  // looked at in IDLE.
  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    case (state)
      INIT: begin
        sweep_cnt_nxt = sweep_cnt + 1'b1;
        if (&sweep_cnt) begin
          state_nxt     = IDLE;
          sweep_cnt_nxt = '0;
        end
      end
      IDLE: begin
        if (flush_req) begin
          state_nxt     = INIT;
          sweep_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = INIT;
        sweep_cnt_nxt = '0;
      end
    endcase
  end

  assign init_busy = (state == INIT);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Port arbitration: sweep > write > lookup
  // ---------------------------------------------------------------------------
  logic               sweep_en;
  logic               wr_acc;
  logic               rd_acc;
  logic [INDEX_W-1:0] mem_addr;
  tag_entry_t         tag_din;

  assign sweep_en = init_busy;
  assign wr_acc   = wr_vld & ~init_busy;
  assign rd_rdy   = ~init_busy & ~wr_vld;
  assign rd_acc   = rd_vld & rd_rdy;

  always_comb begin
    mem_addr = rd_index;
    if (sweep_en) begin
      mem_addr = sweep_cnt;
    end else if (wr_acc) begin
      mem_addr = wr_index;
    end
  end

  always_comb begin
    tag_din = '0;
    if (!sweep_en) begin
      tag_din.valid = wr_valid;
      tag_din.tag   = wr_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Way storage
  // ---------------------------------------------------------------------------
  tag_entry_t        tag_dout  [WAYS];
  logic [LINE_W-1:0] data_dout [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_sel;
    logic tag_en;
    logic tag_we;
    logic data_en;
    logic data_we;

    assign way_sel = wr_acc & (wr_way == WAY_W'(w));
    // Tag array: every way is cleared on sweep and read on lookup; only the
    // addressed way is touched by a write.
    assign tag_we  = sweep_en | way_sel;
    assign tag_en  = tag_we | rd_acc;
    // Data banks stay idle during the sweep and on tag-only writes.
    assign data_we = way_sel & wr_data_en;
    assign data_en = data_we | rd_acc;

    icache_way_mem #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .LINE_W  (LINE_W),
      .BANKS   (BANKS)
    ) u_way_mem (
      .clk       (clk),
      .addr      (mem_addr),
      .tag_en    (tag_en),
      .tag_we    (tag_we),
      .tag_din   (tag_din),
      .tag_dout  (tag_dout[w]),
      .data_en   (data_en),
      .data_we   (data_we),
      .data_din  (wr_line),
      .data_dout (data_dout[w])
    );
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline
  //   stage 0: accept, arrays read, tag captured
  //   stage 1: compare against array outputs, select line
  //   stage 2: registered response
  // ---------------------------------------------------------------------------
  logic             s1_vld;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_tag <= '0;
    end else begin
      s1_vld <= rd_acc;
      if (rd_acc) begin
        s1_tag <= rd_tag;
      end
    end
  end

  logic [WAYS-1:0]   hit;
  logic [LINE_W-1:0] line_sel;
  logic              multi_hit;

  // Lines of all hitting ways are OR-ed together; with a single hit this is
  // a plain mux, with a multi-hit the result is deliberately the OR.
  always_comb begin
    hit      = '0;
    line_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = s1_vld & tag_dout[w].valid & (tag_dout[w].tag == s1_tag);
      if (hit[w]) begin
        line_sel = line_sel | data_dout[w];
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_hit = |(hit & (hit - WAYS'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld       <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_hit_way   <= '0;
      rsp_multi_hit <= 1'b0;
      rsp_line      <= '0;
    end else begin
      rsp_vld       <= s1_vld;
      rsp_hit       <= |hit;
      rsp_hit_way   <= hit;
      rsp_multi_hit <= multi_hit;
      rsp_line      <= line_sel;
    end
  end

endmodule : icache_mem_nway

// File: tb/tb_icache_mem_nway.sv
// -----------------------------------------------------------------------------
// tb_icache_mem_nway
// Directed and random stimulus against icache_mem_nway with a behavioural
// model of the cache contents (per-way valid/tag/line arrays) and a busy
// counter for the tag sweep. Expected responses are queued with their due
// cycle and compared when that cycle comes around.
// -----------------------------------------------------------------------------
module tb_icache_mem_nway;
  import icache_mem_nway_pkg::*;

  localparam int WAYS    = 4;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 20;
  localparam int LINE_W  = 512;
  localparam int BANKS   = 2;
  localparam int WAY_W   = 2;
  localparam int DEPTH   = 64;
  localparam int RW      = LINE_W + WAYS + 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               rst;
  logic               flush_req;
  logic               init_busy;
  logic               rd_vld;
  logic               rd_rdy;
  logic [INDEX_W-1:0] rd_index;
  logic [TAG_W-1:0]   rd_tag;
  logic               rsp_vld;
  logic               rsp_hit;
  logic [WAYS-1:0]    rsp_hit_way;
  logic               rsp_multi_hit;
  logic [LINE_W-1:0]  rsp_line;
  logic               wr_vld;
  logic [INDEX_W-1:0] wr_index;
  logic [WAY_W-1:0]   wr_way;
  logic               wr_valid;
  logic [TAG_W-1:0]   wr_tag;
  logic               wr_data_en;
  logic [LINE_W-1:0]  wr_line;
  icache_mem_state_e  state_dbg;

  always #5 clk = ~clk;

  icache_mem_nway #(
    .WAYS    (WAYS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W),
    .BANKS   (BANKS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_req     (flush_req),
    .init_busy     (init_busy),
    .rd_vld        (rd_vld),
    .rd_rdy        (rd_rdy),
    .rd_index      (rd_index),
    .rd_tag        (rd_tag),
    .rsp_vld       (rsp_vld),
    .rsp_hit       (rsp_hit),
    .rsp_hit_way   (rsp_hit_way),
    .rsp_multi_hit (rsp_multi_hit),
    .rsp_line      (rsp_line),
    .wr_vld        (wr_vld),
    .wr_index      (wr_index),
    .wr_way        (wr_way),
    .wr_valid      (wr_valid),
    .wr_tag        (wr_tag),
    .wr_data_en    (wr_data_en),
    .wr_line       (wr_line),
    .state_dbg     (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic              vm [WAYS][DEPTH];
  logic [TAG_W-1:0]  tm [WAYS][DEPTH];
  logic [LINE_W-1:0] dm [WAYS][DEPTH];

  logic [RW-1:0] exp_q[$];   // {hit, multi_hit, hit_way, line}
  int            due_q[$];   // cycle in which the response must appear
  int            busy_left;  // remaining sweep cycles
  int            cyc;
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One clock cycle with the inputs already driven: check this cycle's
  // outputs, advance the model, then move to the next falling edge.
  task automatic tick();
    logic [RW-1:0]     e;
    logic [WAYS-1:0]   ew;
    logic [LINE_W-1:0] el;
    int                nhit;
    bit                rd_acc;
    bit                wr_acc;
    bit                flush_take;
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      chk("rsp_vld",       LINE_W'(rsp_vld),       LINE_W'(1'b1));
      chk("rsp_hit",       LINE_W'(rsp_hit),       LINE_W'(e[RW-1]));
      chk("rsp_multi_hit", LINE_W'(rsp_multi_hit), LINE_W'(e[RW-2]));
      chk("rsp_hit_way",   LINE_W'(rsp_hit_way),   LINE_W'(e[LINE_W +: WAYS]));
      chk("rsp_line",      rsp_line,               e[LINE_W-1:0]);
    end else begin
      chk("rsp_vld_idle", LINE_W'(rsp_vld), LINE_W'(1'b0));
    end
    chk("init_busy", LINE_W'(init_busy), LINE_W'(busy_left != 0));
    chk("rd_rdy",    LINE_W'(rd_rdy),    LINE_W'(busy_left == 0 && !wr_vld));

    rd_acc     = rd_vld && !wr_vld && busy_left == 0;
    wr_acc     = wr_vld && busy_left == 0;
    flush_take = flush_req && busy_left == 0;

    if (rd_acc) begin
      ew   = '0;
      el   = '0;
      nhit = 0;
      for (int w = 0; w < WAYS; w++) begin
        if (vm[w][rd_index] && tm[w][rd_index] == rd_tag) begin
          ew[w] = 1'b1;
          el    = el | dm[w][rd_index];
          nhit++;
        end
      end
      exp_q.push_back({nhit > 0, nhit > 1, ew, el});
      due_q.push_back(cyc + 2);
    end
    if (wr_acc) begin
      vm[wr_way][wr_index] = wr_valid;
      tm[wr_way][wr_index] = wr_tag;
      if (wr_data_en) dm[wr_way][wr_index] = wr_line;
    end

    @(posedge clk);
    cyc++;
    if (flush_take) begin
      busy_left = DEPTH;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < DEPTH; s++) vm[w][s] = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    rd_vld     = 1'b0;
    wr_vld     = 1'b0;
    flush_req  = 1'b0;
    wr_valid   = 1'b0;
    wr_data_en = 1'b0;
  endtask

  task automatic lookup(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    set_idle();
    rd_vld   = 1'b1;
    rd_index = idx;
    rd_tag   = tag;
    tick();
  endtask

  task automatic write(input logic [INDEX_W-1:0] idx, input logic [WAY_W-1:0] way,
                       input logic valid, input logic [TAG_W-1:0] tag,
                       input logic den, input logic [LINE_W-1:0] line);
    set_idle();
    wr_vld     = 1'b1;
    wr_index   = idx;
    wr_way     = way;
    wr_valid   = valid;
    wr_tag     = tag;
    wr_data_en = den;
    wr_line    = line;
    tick();
  endtask

  task automatic drain(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] inc_line;
  logic [LINE_W-1:0] l0;
  logic [LINE_W-1:0] l1;

  initial begin
    set_idle();
    rd_index = '0;
    rd_tag   = '0;
    wr_index = '0;
    wr_way   = '0;
    wr_tag   = '0;
    wr_line  = '0;
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < DEPTH; s++) begin
        vm[w][s] = 1'b0;
        tm[w][s] = '0;
        dm[w][s] = '0;
      end

    // Reset: three cycles, then check reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rsp_vld",   LINE_W'(rsp_vld),       '0);
    chk("rst_rsp_hit",   LINE_W'(rsp_hit),       '0);
    chk("rst_hit_way",   LINE_W'(rsp_hit_way),   '0);
    chk("rst_multi_hit", LINE_W'(rsp_multi_hit), '0);
    chk("rst_rsp_line",  rsp_line,               '0);
    chk("rst_init_busy", LINE_W'(init_busy),     LINE_W'(1'b1));
    chk("rst_rd_rdy",    LINE_W'(rd_rdy),        '0);
    @(negedge clk);
    rst       = 1'b0;
    busy_left = DEPTH;
    cyc       = 0;

    // Sweep with lookups pressing: none may be accepted.
    for (int i = 0; i < DEPTH; i++) begin
      rd_vld   = 1'b1;
      rd_index = INDEX_W'($urandom_range(0, DEPTH - 1));
      rd_tag   = '0;
      tick();
    end
    lookup(0, 0);
    drain(3);

    // Refill and hit / miss.
    for (int i = 0; i < LINE_W / 8; i++) inc_line[i*8 +: 8] = 8'(i);
    write(5, 2, 1'b1, 20'h01234, 1'b1, inc_line);
    lookup(5, 20'h01234);
    lookup(5, 20'h01235);
    drain(3);

    // Write/lookup collision on the same set.
    l0 = rand_line();
    set_idle();
    wr_vld     = 1'b1;
    wr_index   = 7;
    wr_way     = 1;
    wr_valid   = 1'b1;
    wr_tag     = 20'h00055;
    wr_data_en = 1'b1;
    wr_line    = l0;
    rd_vld     = 1'b1;
    rd_index   = 7;
    rd_tag     = 20'h00055;
    tick();
    wr_vld = 1'b0;
    tick();
    drain(3);

    // Tag-only invalidate, then tag-only revalidate keeps the old line.
    write(5, 2, 1'b0, 20'h01234, 1'b0, '0);
    lookup(5, 20'h01234);
    write(5, 2, 1'b1, 20'h01234, 1'b0, '0);
    lookup(5, 20'h01234);
    drain(3);

    // Flush with two lookups in flight; a flush during the sweep is ignored.
    lookup(5, 20'h01234);
    set_idle();
    rd_vld    = 1'b1;
    rd_index  = 7;
    rd_tag    = 20'h00055;
    flush_req = 1'b1;
    tick();
    for (int i = 0; i < DEPTH + 4; i++) begin
      set_idle();
      rd_vld    = 1'b1;
      rd_index  = INDEX_W'($urandom_range(0, DEPTH - 1));
      rd_tag    = TAG_W'($urandom_range(0, 3));
      flush_req = (i == 20);
      tick();
    end
    lookup(5, 20'h01234);
    lookup(7, 20'h00055);
    drain(3);

    // Multi-hit.
    l0 = rand_line();
    l1 = rand_line();
    write(9, 0, 1'b1, 20'h00077, 1'b1, l0);
    write(9, 3, 1'b1, 20'h00077, 1'b1, l1);
    lookup(9, 20'h00077);
    drain(3);

    // Random traffic over a small set/tag space.
    for (int i = 0; i < 600; i++) begin
      set_idle();
      rd_vld   = ($urandom_range(0, 99) < 60);
      rd_index = INDEX_W'($urandom_range(0, 3));
      rd_tag   = TAG_W'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 25) begin
        wr_vld     = 1'b1;
        wr_index   = INDEX_W'($urandom_range(0, 3));
        wr_way     = WAY_W'($urandom_range(0, WAYS - 1));
        wr_tag     = TAG_W'($urandom_range(0, 3));
        wr_valid   = ($urandom_range(0, 99) < 75);
        wr_data_en = wr_valid ? 1'b1 : 1'($urandom_range(0, 1));
        wr_line    = rand_line();
      end
      flush_req = ($urandom_range(0, 299) == 0);
      tick();
    end
    drain(4);
    chk("queue_drained", LINE_W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_icache_mem_nway
